// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
//
// Performance monitor for an in-order CPU pipeline. It counts cycles, load-use
// stalls, branch flushes and retired instructions during a run window. The
// window opens on start_i and closes on halt_i or when the cycle budget is
// reached. After that the counts are frozen until clear_i or rst_i.
//
// Optional feature (macro PERF_MONITOR_SNAPSHOT_EN):
//   Adds snap_i and four shadow registers. snap_i copies the post-update
//   counter values. sel_i widens to 3 bits, and codes 4..7 read the shadows.
//
// Parameters
//   CNT_W       width of each counter; counters saturate at all-ones
//   MAX_CYCLES  cycle budget that ends the run; 0 = unlimited
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous reset, active-high
//   start_i      in   opens a run when seen high in IDLE
//   stall_i      in   hazard-detection stall request
//   branch_i     in   branch decode in ID (masks stall_i)
//   flush_i      in   branch-taken flush of IF/ID
//   retire_i     in   one retired instruction
//   halt_i       in   forces end of run
//   clear_i      in   synchronous clear of counters and FSM
//   snap_i       in   (snapshot build only) capture shadow copies
//   sel_i        in   readout select: 0=cycles 1=stalls 2=flushes 3=retired
//                     (4..7 = shadows in snapshot build)
//   rd_data_o    out  registered selected counter, 1-cycle latency
//   running_o    out  high while in RUN
//   done_o       out  high while in DONE
//   dbg_state_o  out  raw FSM state (0=IDLE 1=RUN 2=DONE)
//
// Handshake: there is no valid/ready handshake. All inputs are sampled as
// levels on every rising edge. rd_data_o is always valid one edge after
// sel_i is presented.
// -----------------------------------------------------------------------------
module perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             halt_i,
  input  logic             clear_i,
`ifdef PERF_MONITOR_SNAPSHOT_EN
  input  logic             snap_i,
  input  logic [2:0]       sel_i,
`else
  input  logic [1:0]       sel_i,
`endif
  output logic [CNT_W-1:0] rd_data_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cyc, r_stl, r_fls, r_ret;
  logic [CNT_W-1:0] w_cyc_nxt, w_stl_nxt, w_fls_nxt, w_ret_nxt;
  logic             w_cnt_en;
  logic             w_budget_hit;
  logic             w_running_nxt, w_done_nxt;
  logic [CNT_W-1:0] w_rd_sel;
  logic             r_running, r_done;
  logic [CNT_W-1:0] r_rd_data;

  localparam logic [63:0] MAX_CYC_EXT = 64'(MAX_CYCLES);

  // Counting happens on every edge spent in RUN, including the edge that
  // leaves RUN, so the terminating cycle is included in the totals.
  assign w_cnt_en = (r_state == ST_RUN);

  // Saturating increments. A counter that is already all-ones holds its value.
  assign w_cyc_nxt = (w_cnt_en && !(&r_cyc)) ? r_cyc + 1'b1 : r_cyc;
  assign w_stl_nxt = (w_cnt_en && stall_i && !branch_i && !(&r_stl))
                     ? r_stl + 1'b1 : r_stl;
  assign w_fls_nxt = (w_cnt_en && flush_i && !(&r_fls)) ? r_fls + 1'b1 : r_fls;
  assign w_ret_nxt = (w_cnt_en && retire_i && !(&r_ret)) ? r_ret + 1'b1 : r_ret;

  // The budget is compared against the post-increment value. The run
  // therefore ends on the edge where the count becomes MAX_CYCLES.
  assign w_budget_hit = (MAX_CYCLES != 0) && (64'(w_cyc_nxt) == MAX_CYC_EXT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (clear_i overrides every transition)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
        ST_RUN:  if (halt_i || w_budget_hit) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. It is taken from the next state and then registered,
  // so running_o/done_o change on the transition edge itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_running_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      ST_RUN:  w_running_nxt = 1'b1;
      ST_DONE: w_done_nxt    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters. The next-value wires already hold the current value outside RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cyc <= '0;
      r_stl <= '0;
      r_fls <= '0;
      r_ret <= '0;
    end else begin
      r_cyc <= w_cyc_nxt;
      r_stl <= w_stl_nxt;
      r_fls <= w_fls_nxt;
      r_ret <= w_ret_nxt;
    end
  end

`ifdef PERF_MONITOR_SNAPSHOT_EN
  logic [CNT_W-1:0] r_sh_cyc, r_sh_stl, r_sh_fls, r_sh_ret;

  // Shadows capture the post-update values, so a snapshot includes the
  // effect of the edge on which snap_i was sampled.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_sh_cyc <= '0;
      r_sh_stl <= '0;
      r_sh_fls <= '0;
      r_sh_ret <= '0;
    end else if (snap_i) begin
      r_sh_cyc <= w_cyc_nxt;
      r_sh_stl <= w_stl_nxt;
      r_sh_fls <= w_fls_nxt;
      r_sh_ret <= w_ret_nxt;
    end
  end

  always_comb begin
    w_rd_sel = '0;
    case (sel_i)
      3'd0: w_rd_sel = r_cyc;
      3'd1: w_rd_sel = r_stl;
      3'd2: w_rd_sel = r_fls;
      3'd3: w_rd_sel = r_ret;
      3'd4: w_rd_sel = r_sh_cyc;
      3'd5: w_rd_sel = r_sh_stl;
      3'd6: w_rd_sel = r_sh_fls;
      3'd7: w_rd_sel = r_sh_ret;
      default: w_rd_sel = '0;
    endcase
  end
`else
  always_comb begin
    w_rd_sel = '0;
    case (sel_i)
      2'd0: w_rd_sel = r_cyc;
      2'd1: w_rd_sel = r_stl;
      2'd2: w_rd_sel = r_fls;
      2'd3: w_rd_sel = r_ret;
      default: w_rd_sel = '0;
    endcase
  end
`endif

  // Readout registers the pre-update counter values, which gives one edge
  // of latency.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_sel;
    end
  end

  assign rd_data_o   = r_rd_data;
  assign running_o   = r_running;
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

endmodule
